light_countdown: RTL and testbench
==================================

# light_countdown

Countdown display stage sitting directly downstream of the traffic-light sequencer. Observes the sequencer's `ledR`/`ledG` outputs, decodes the current phase (red, green, yellow, off) and displays the whole seconds remaining in that phase on a two-digit multiplexed 7-segment display. Durations are parameters matched to the sequencer's phase lengths. The block never drives the lights; it only follows them.

## Interface
- `CLK_HZ`, 125_000_000: clock cycles per second; prescaler period.
- `RED_S`, 5: red phase length in seconds, 1..99.
- `GRN_S`, 5: green phase length in seconds, 1..99.
- `YEL_S`, 3: yellow phase length in seconds, 1..99.
- `REFRESH_DIV`, 125_000: cycles per digit-select toggle, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low (asserted when 0).
- `ledR`  in  1  red lamp from sequencer, same clock domain.
- `ledG`  in  1  green lamp from sequencer; `ledR & ledG` means yellow.
- `phase`  out  2  registered phase: 00 off, 01 red, 10 green, 11 yellow.
- `sec_tens`  out  4  BCD tens digit of seconds remaining.
- `sec_ones`  out  4  BCD ones digit of seconds remaining.
- `sec_tick`  out  1  one-cycle pulse on each one-second decrement.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  2  digit enables, active-low; `an[0]` ones, `an[1]` tens.

## Operation
- Phase decode: `cur = {ledG, ledR}` maps {0,0}→off, {0,1}→red, {1,0}→green, {1,1}→yellow.
- `phase` register holds the last sampled `cur`. A phase change is `cur != phase` at a clock edge.
- On a phase change at edge E, all of the following happen:
  - `phase` ← `cur`.
  - {`sec_tens`,`sec_ones`} ← BCD of the new phase's duration (off loads 00).
  - Prescaler clears to 0.
  - `sec_tick` = 0 in that cycle.
- With no phase change, the prescaler counts 0..CLK_HZ-1 and wraps. On wrap:
  - If the count is nonzero, decrement it in BCD: ones 0 borrows from tens, and ones goes to 9.
  - `sec_tick` = 1 for that cycle only.
- Count saturates at 00. At 00, a wrap produces no decrement and no tick.
- In the off phase, the prescaler holds at 0 and the count holds at 00.
- Display refresh counter counts 0..REFRESH_DIV-1. On wrap, digit select toggles between ones and tens.
  - Ones selected: `an` = 10, `seg` = pattern of `sec_ones`.
  - Tens selected: `an` = 01 and `seg` = pattern of `sec_tens`, unless `sec_tens` = 0, in which case `an` = 11 (leading blank).
  - Phase off: `an` = 11 and `seg` = 7'h7F.
- Decoder for 0-9, active-low (a=bit0): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex). Codes above 9 are unreachable and drive 7F.
- `seg` and `an` are registered; no combinational path from inputs to outputs.

## Timing
- Reset (`rst`=0 at an edge), required state after that edge:
  - `phase`=00, `sec_tens`=0, `sec_ones`=0, `sec_tick`=0.
  - `seg`=7F, `an`=11.
  - Prescaler, refresh counter and digit select all 0.
- Reset has priority over every event. Reset asserted mid-countdown blanks the display at the next edge.
- Reset release: the first edge with `rst`=1 samples the lamps normally. A non-off input therefore loads its duration at that edge.
- Latency from lamp change to `phase`/digits: 1 cycle. To `seg`/`an`: 2 cycles.
- First decrement occurs CLK_HZ cycles after the load edge. A phase of N seconds shows N, N-1, …, 1, each for CLK_HZ cycles. The sequencer's next change then reloads the count.
- Simultaneous phase change and prescaler wrap: the change wins. The count loads, no decrement, no tick.
- Unexpected transitions (e.g. red→off, green→red) are treated as ordinary phase changes. There is no ordering check.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `ledR`=1 → `phase`=00, digits 00, `seg`=7F, `an`=11; release → `phase`=01 and digits 05 one cycle later.
- Red countdown (CLK_HZ=10, REFRESH_DIV=2): `ledR`=1 held for 60 cycles → digits 5,4,3,2,1,0 each for 10 cycles; `sec_tick` pulses at cycles 10, 20, 30, 40, 50; digits stay 00 with no tick at cycle 60.
- Full sequence: drive red 50, green 50, yellow 30 cycles (CLK_HZ=10) → reload to 05, 05, 03 at each change; tens digit always blanked (`an`=11 during the tens slot).
- Two-digit borrow: set RED_S=12 → digits 12, 11, 10, 09; at 09 the tens slot is blanked and the ones `seg` = 7'h10.
- Collision: change `ledG` on the exact cycle the prescaler wraps → new duration loaded, no decrement, `sec_tick`=0.
- Mid-run reset: assert `rst`=0 while showing 03 → next edge `seg`=7F, `an`=11, digits 00.

Source files
------------

// File: rtl/light_countdown.sv
// Countdown display that follows the traffic-light sequencer's lamps and shows the
// whole seconds left in the current phase on a two-digit multiplexed 7-segment display.
module light_countdown #(
  parameter int CLK_HZ      = 125_000_000,
  parameter int RED_S       = 5,
  parameter int GRN_S       = 5,
  parameter int YEL_S       = 3,
  parameter int REFRESH_DIV = 125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ledR,
  input  logic       ledG,
  output logic [1:0] phase,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic [6:0] seg,
  output logic [1:0] an
);

  typedef enum logic [1:0] {
    PH_OFF = 2'b00,
    PH_RED = 2'b01,
    PH_GRN = 2'b10,
    PH_YEL = 2'b11
  } phase_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);

  localparam logic [7:0] RED_BCD = {4'(RED_S / 10), 4'(RED_S % 10)};
  localparam logic [7:0] GRN_BCD = {4'(GRN_S / 10), 4'(GRN_S % 10)};
  localparam logic [7:0] YEL_BCD = {4'(YEL_S / 10), 4'(YEL_S % 10)};

  phase_t        cur;
  phase_t        ph_q;
  logic [PW-1:0] presc;
  logic [RW-1:0] refresh;
  logic          sel;  // 0: ones digit, 1: tens digit

  assign cur   = phase_t'({ledG, ledR});
  assign phase = ph_q;

  function automatic logic [7:0] load_bcd(input phase_t p);
    case (p)
      PH_RED:  return RED_BCD;
      PH_GRN:  return GRN_BCD;
      PH_YEL:  return YEL_BCD;
      default: return 8'h00;
    endcase
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes are blanked.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Phase tracking, prescaler and BCD countdown. A phase change outranks a
  // simultaneous prescaler wrap, so a fresh load never loses its first second.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ph_q     <= PH_OFF;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      sec_tick <= 1'b0;
      presc    <= '0;
    end else begin
      sec_tick <= 1'b0;
      if (cur != ph_q) begin
        ph_q                 <= cur;
        {sec_tens, sec_ones} <= load_bcd(cur);
        presc                <= '0;
      end else if (ph_q == PH_OFF) begin
        presc <= '0;
      end else if (presc == PRESC_MAX) begin
        presc <= '0;
        if ({sec_tens, sec_ones} != 8'h00) begin
          sec_tick <= 1'b1;
          if (sec_ones == 4'd0) begin
            sec_tens <= sec_tens - 4'd1;
            sec_ones <= 4'd9;
          end else begin
            sec_ones <= sec_ones - 4'd1;
          end
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Digit multiplexing; outputs are built from registered state only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh <= '0;
      sel     <= 1'b0;
      seg     <= 7'h7F;
      an      <= 2'b11;
    end else begin
      if (refresh == REF_MAX) begin
        refresh <= '0;
        sel     <= ~sel;
      end else begin
        refresh <= refresh + 1'b1;
      end

      if (ph_q == PH_OFF) begin
        an  <= 2'b11;
        seg <= 7'h7F;
      end else if (!sel) begin
        an  <= 2'b10;
        seg <= seg_of(sec_ones);
      end else if (sec_tens == 4'd0) begin
        an  <= 2'b11;
        seg <= 7'h7F;
      end else begin
        an  <= 2'b01;
        seg <= seg_of(sec_tens);
      end
    end
  end

endmodule

// File: tb/tb_light_countdown.sv
// Self-checking bench for light_countdown: two instances (red 5 s and red 12 s)
// compared every cycle against a seconds-based reference model through a scoreboard.
module tb_light_countdown;

  localparam int CLK_HZ = 10;
  localparam int RD     = 2;
  localparam int SEG_TBL [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  logic clk = 1'b0;
  logic rst, ledR, ledG;

  logic [1:0] a_phase, b_phase, a_an, b_an;
  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic       a_tick, b_tick;
  logic [6:0] a_seg, b_seg;

  light_countdown #(.CLK_HZ(CLK_HZ), .RED_S(5), .GRN_S(5), .YEL_S(3), .REFRESH_DIV(RD)) dut_a (
    .clk(clk), .rst(rst), .ledR(ledR), .ledG(ledG),
    .phase(a_phase), .sec_tens(a_tens), .sec_ones(a_ones), .sec_tick(a_tick),
    .seg(a_seg), .an(a_an)
  );

  light_countdown #(.CLK_HZ(CLK_HZ), .RED_S(12), .GRN_S(5), .YEL_S(3), .REFRESH_DIV(RD)) dut_b (
    .clk(clk), .rst(rst), .ledR(ledR), .ledG(ledG),
    .phase(b_phase), .sec_tens(b_tens), .sec_ones(b_ones), .sec_tick(b_tick),
    .seg(b_seg), .an(b_an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph; int rem; int pc; int rc; int sel; int tick; int seg; int an;
  } mstate_t;

  typedef struct {
    int ph; int tens; int ones; int tick; int seg; int an;
  } exp_t;

  exp_t    q_a[$];
  exp_t    q_b[$];
  mstate_t m_a, m_b;
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dur(input int p, input int red_s);
    case (p)
      1:       return red_s;
      2:       return 5;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  // Reference model: remaining time kept as an integer number of seconds.
  // seg = -1 marks the blanked tens slot, whose segment value is not checked.
  function automatic mstate_t step(input mstate_t s, input bit r, input bit lr,
                                   input bit lg, input int red_s);
    mstate_t n = s;
    int      cur = (lg ? 2 : 0) + (lr ? 1 : 0);
    if (!r) begin
      n = '{ph: 0, rem: 0, pc: 0, rc: 0, sel: 0, tick: 0, seg: 'h7F, an: 3};
      return n;
    end
    if (s.ph == 0) begin
      n.seg = 'h7F; n.an = 3;
    end else if (s.sel == 0) begin
      n.an = 2; n.seg = SEG_TBL[s.rem % 10];
    end else if (s.rem / 10 == 0) begin
      n.an = 3; n.seg = -1;
    end else begin
      n.an = 1; n.seg = SEG_TBL[s.rem / 10];
    end
    if (s.rc == RD - 1) begin
      n.rc = 0; n.sel = 1 - s.sel;
    end else begin
      n.rc = s.rc + 1;
    end
    n.tick = 0;
    if (cur != s.ph) begin
      n.ph = cur; n.rem = dur(cur, red_s); n.pc = 0;
    end else if (s.ph == 0) begin
      n.pc = 0;
    end else if (s.pc == CLK_HZ - 1) begin
      n.pc = 0;
      if (s.rem > 0) begin
        n.rem = s.rem - 1; n.tick = 1;
      end
    end else begin
      n.pc = s.pc + 1;
    end
    return n;
  endfunction

  function automatic exp_t outs(input mstate_t s);
    exp_t e;
    e.ph = s.ph; e.tens = s.rem / 10; e.ones = s.rem % 10;
    e.tick = s.tick; e.seg = s.seg; e.an = s.an;
    return e;
  endfunction

  // One clock: drive inputs, push the model's prediction, then compare after the edge.
  task automatic cycle(input bit r, input bit lr, input bit lg);
    exp_t e;
    rst = r; ledR = lr; ledG = lg;
    m_a = step(m_a, r, lr, lg, 5);
    m_b = step(m_b, r, lr, lg, 12);
    q_a.push_back(outs(m_a));
    q_b.push_back(outs(m_b));
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check("a.phase", 32'(a_phase), 32'(e.ph));
    check("a.tens",  32'(a_tens),  32'(e.tens));
    check("a.ones",  32'(a_ones),  32'(e.ones));
    check("a.tick",  32'(a_tick),  32'(e.tick));
    check("a.an",    32'(a_an),    32'(e.an));
    if (e.seg >= 0) check("a.seg", 32'(a_seg), 32'(e.seg));
    e = q_b.pop_front();
    check("b.phase", 32'(b_phase), 32'(e.ph));
    check("b.tens",  32'(b_tens),  32'(e.tens));
    check("b.ones",  32'(b_ones),  32'(e.ones));
    check("b.tick",  32'(b_tick),  32'(e.tick));
    check("b.an",    32'(b_an),    32'(e.an));
    if (e.seg >= 0) check("b.seg", 32'(b_seg), 32'(e.seg));
  endtask

  initial begin
    int ticks;
    int tens_shown;
    m_a = '{default: 0};
    m_b = '{default: 0};
    rst = 1'b0; ledR = 1'b1; ledG = 1'b0;
    @(negedge clk);

    // Reset held with red lamp on
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    check("rst.phase", 32'(a_phase), 32'd0);
    check("rst.digits", 32'({a_tens, a_ones}), 32'h00);
    check("rst.seg", 32'(a_seg), 32'h7F);
    check("rst.an", 32'(a_an), 32'd3);

    // Release: red loads at the first edge
    cycle(1'b1, 1'b1, 1'b0);
    check("rel.phase", 32'(a_phase), 32'd1);
    check("rel.digits", 32'({a_tens, a_ones}), 32'h05);
    check("rel.digits12", 32'({b_tens, b_ones}), 32'h12);

    // Red countdown to saturation
    ticks = 0;
    for (int i = 0; i < 61; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (a_tick) ticks++;
    end
    check("red.ticks", 32'(ticks), 32'd5);
    check("red.sat", 32'({a_tens, a_ones}), 32'h00);

    // Green then yellow: single-digit phases never light the tens digit
    tens_shown = 0;
    cycle(1'b1, 1'b0, 1'b1);
    check("grn.load", 32'({a_tens, a_ones}), 32'h05);
    for (int i = 0; i < 49; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (a_an == 2'b01) tens_shown++;
    end
    cycle(1'b1, 1'b1, 1'b1);
    check("yel.load", 32'({a_tens, a_ones}), 32'h03);
    for (int i = 0; i < 29; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (a_an == 2'b01) tens_shown++;
    end
    check("tens.blank", 32'(tens_shown), 32'd0);

    // Off phase blanks the display
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    check("off.an", 32'(a_an), 32'd3);
    check("off.seg", 32'(a_seg), 32'h7F);

    // Two-digit borrow on the 12 s instance: 12, 11, 10, 09
    for (int i = 0; i < 36; i++) cycle(1'b1, 1'b1, 1'b0);
    check("b.borrow", 32'({b_tens, b_ones}), 32'h09);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (b_an == 2'b10) check("b.seg9", 32'(b_seg), 32'h10);
      check("b.tens_blank", 32'(b_an == 2'b01), 32'd0);
    end

    // Collision: lamp change on the exact prescaler-wrap edge
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    check("pre.coll", 32'({a_tens, a_ones}), 32'h05);
    cycle(1'b1, 1'b1, 1'b1);
    check("coll.phase", 32'(a_phase), 32'd3);
    check("coll.digits", 32'({a_tens, a_ones}), 32'h03);
    check("coll.tick", 32'(a_tick), 32'd0);

    // Reset while showing 03
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("mrst.seg", 32'(a_seg), 32'h7F);
    check("mrst.an", 32'(a_an), 32'd3);
    check("mrst.digits", 32'({a_tens, a_ones}), 32'h00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
